// File: rtl/text_cursor_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : text_cursor_writer_if
// Description : Command stream and tile-RAM write port of the cursor writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface text_cursor_writer_if #(
    parameter int COLS       = 160,
    parameter int ROWS       = 45,
    parameter int CHAR_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(COLS * ROWS)
);
    localparam int C_COL_W = $clog2(COLS);
    localparam int C_ROW_W = $clog2(ROWS);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_type;
    logic [CHAR_WIDTH-1:0] cmd_char;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [CHAR_WIDTH-1:0] wr_data;
    logic [C_COL_W-1:0]    cursor_col;
    logic [C_ROW_W-1:0]    cursor_row;
    logic                  busy;

    modport master (
        output cmd_valid, cmd_type, cmd_char,
        input  cmd_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_char,
        output cmd_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
    );
endinterface
`default_nettype wire

// File: rtl/text_cursor_writer.sv
`default_nettype none
// ============================================================================
// Module      : text_cursor_writer
// Description : Character-cell terminal writer driving display tile RAM port A.
// Revision    : 1.0 - initial release
// ============================================================================
module text_cursor_writer #(
    parameter int                    COLS       = 160,
    parameter int                    ROWS       = 45,
    parameter int                    CHAR_WIDTH = 8,
    parameter int                    ADDR_WIDTH = $clog2(COLS * ROWS),
    parameter int                    LINE_WRAP  = 1,
    parameter int                    ROW_WRAP   = 1,
    parameter logic [CHAR_WIDTH-1:0] CLEAR_CHAR = CHAR_WIDTH'(8'h20)
) (
    input  logic              clk,
    input  logic              rst_n,
    text_cursor_writer_if.slave bus
);
    localparam int C_COL_W = $clog2(COLS);
    localparam int C_ROW_W = $clog2(ROWS);

    localparam logic [C_COL_W-1:0]    C_LAST_COL  = C_COL_W'(COLS - 1);
    localparam logic [C_ROW_W-1:0]    C_LAST_ROW  = C_ROW_W'(ROWS - 1);
    localparam logic [C_COL_W-1:0]    C_COL_ONE   = C_COL_W'(1);
    localparam logic [C_ROW_W-1:0]    C_ROW_ONE   = C_ROW_W'(1);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] C_COLS_A    = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(COLS * ROWS - 1);

    localparam logic [2:0] C_CMD_PUT   = 3'd0;
    localparam logic [2:0] C_CMD_UP    = 3'd1;
    localparam logic [2:0] C_CMD_DOWN  = 3'd2;
    localparam logic [2:0] C_CMD_LEFT  = 3'd3;
    localparam logic [2:0] C_CMD_RIGHT = 3'd4;
    localparam logic [2:0] C_CMD_NL    = 3'd5;
    localparam logic [2:0] C_CMD_BS    = 3'd6;
    localparam logic [2:0] C_CMD_CLEAR = 3'd7;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [CHAR_WIDTH-1:0] r_wr_data;
    logic [C_COL_W-1:0]    r_col;
    logic [C_ROW_W-1:0]    r_row;
    logic [ADDR_WIDTH-1:0] r_row_base;

    logic [ADDR_WIDTH-1:0] w_cur_addr;
    logic [C_ROW_W-1:0]    w_nl_row;
    logic [ADDR_WIDTH-1:0] w_nl_base;
    logic                  w_accept;

    // r_row_base tracks r_row*COLS so the cell address needs only an adder.
    assign w_cur_addr = r_row_base + ADDR_WIDTH'(r_col);
    assign w_accept   = bus.cmd_valid && r_ready && (r_state == S_IDLE);

    // Row reached by a line feed, shared by NEWLINE and PUT line wrap.
    always_comb begin
        w_nl_row  = r_row;
        w_nl_base = r_row_base;
        if (r_row != C_LAST_ROW) begin
            w_nl_row  = r_row + C_ROW_ONE;
            w_nl_base = r_row_base + C_COLS_A;
        end else if (ROW_WRAP != 0) begin
            w_nl_row  = '0;
            w_nl_base = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        case (bus.cmd_type)
                            C_CMD_PUT: begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= w_cur_addr;
                                r_wr_data <= bus.cmd_char;
                                if (r_col != C_LAST_COL) begin
                                    r_col <= r_col + C_COL_ONE;
                                end else if (LINE_WRAP != 0) begin
                                    r_col      <= '0;
                                    r_row      <= w_nl_row;
                                    r_row_base <= w_nl_base;
                                end
                            end
                            C_CMD_UP: begin
                                if (r_row != '0) begin
                                    r_row      <= r_row - C_ROW_ONE;
                                    r_row_base <= r_row_base - C_COLS_A;
                                end
                            end
                            C_CMD_DOWN: begin
                                if (r_row != C_LAST_ROW) begin
                                    r_row      <= r_row + C_ROW_ONE;
                                    r_row_base <= r_row_base + C_COLS_A;
                                end
                            end
                            C_CMD_LEFT: begin
                                if (r_col != '0) begin
                                    r_col <= r_col - C_COL_ONE;
                                end
                            end
                            C_CMD_RIGHT: begin
                                if (r_col != C_LAST_COL) begin
                                    r_col <= r_col + C_COL_ONE;
                                end
                            end
                            C_CMD_NL: begin
                                r_col      <= '0;
                                r_row      <= w_nl_row;
                                r_row_base <= w_nl_base;
                            end
                            C_CMD_BS: begin
                                // Both cases erase the cell linearly preceding the cursor.
                                if (r_col != '0) begin
                                    r_col     <= r_col - C_COL_ONE;
                                    r_wr_en   <= 1'b1;
                                    r_wr_addr <= w_cur_addr - C_ADDR_ONE;
                                    r_wr_data <= CLEAR_CHAR;
                                end else if (r_row != '0) begin
                                    r_col      <= C_LAST_COL;
                                    r_row      <= r_row - C_ROW_ONE;
                                    r_row_base <= r_row_base - C_COLS_A;
                                    r_wr_en    <= 1'b1;
                                    r_wr_addr  <= r_row_base - C_ADDR_ONE;
                                    r_wr_data  <= CLEAR_CHAR;
                                end
                            end
                            C_CMD_CLEAR: begin
                                r_state    <= S_CLEAR;
                                r_ready    <= 1'b0;
                                r_busy     <= 1'b1;
                                r_wr_en    <= 1'b1;
                                r_wr_addr  <= '0;
                                r_wr_data  <= CLEAR_CHAR;
                                r_col      <= '0;
                                r_row      <= '0;
                                r_row_base <= '0;
                            end
                            default: begin
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_CLEAR: begin
                    if (r_wr_addr == C_LAST_ADDR) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_wr_addr + C_ADDR_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = r_ready;
    assign bus.busy       = r_busy;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.cursor_col = r_col;
    assign bus.cursor_row = r_row;

endmodule
`default_nettype wire
